// File: rtl/logic_sweep_ctrl_pkg.sv
// Shared constants for the exhaustive 5-input logic sweep controller.
package logic_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int         NVEC     = 32;
  localparam logic [4:0] LAST_VEC = 5'd31;

  function automatic logic is_busy(input state_e s);
    return (s == ST_DRIVE) || (s == ST_SAMPLE);
  endfunction

endpackage

// File: rtl/logic_sweep_ctrl_if.sv
// Control, function-unit and result signals of the logic sweep controller.
interface logic_sweep_ctrl_if;
  import logic_sweep_ctrl_pkg::*;

  logic            start;
  logic            abort;
  logic            f_in;
  logic            g_in;
  logic [4:0]      abcde;
  logic            busy;
  logic            done;
  logic            pass;
  logic [5:0]      mismatch_cnt;
  logic [4:0]      first_fail;
  logic [NVEC-1:0] minterms;

  modport master (
    output start, abort, f_in, g_in,
    input  abcde, busy, done, pass, mismatch_cnt, first_fail, minterms
  );

  modport slave (
    input  start, abort, f_in, g_in,
    output abcde, busy, done, pass, mismatch_cnt, first_fail, minterms
  );
endinterface

// File: rtl/logic_sweep_ctrl.sv
// Sweeps all 32 A..E vectors, compares f_in against g_in and logs the result.
// Optional truth-table capture of f_in: define LOGIC_SWEEP_MINTERM_LOG_EN.
module logic_sweep_ctrl
  import logic_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_sweep_ctrl_if.slave bus
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e     r_state;
  state_e     w_next_state;
  logic [4:0] r_vec;
  logic [3:0] r_settle;
  logic [5:0] r_mismatch_cnt;
  logic [4:0] r_first_fail;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic       w_start;
  logic       w_abort;
  logic       w_sample;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; abort beats start while busy, start beats abort when idle
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_abort      = 1'b0;
    w_sample     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          w_next_state = ST_DRIVE;
          w_start      = 1'b1;
        end else begin
          w_next_state = r_state;
        end
      end
      ST_DRIVE: begin
        if (bus.abort) begin
          w_next_state = ST_IDLE;
          w_abort      = 1'b1;
        end else if (r_settle == SETTLE_LAST) begin
          w_next_state = ST_SAMPLE;
        end else begin
          w_next_state = ST_DRIVE;
        end
      end
      ST_SAMPLE: begin
        if (bus.abort) begin
          w_next_state = ST_IDLE;
          w_abort      = 1'b1;
        end else begin
          w_sample     = 1'b1;
          w_next_state = (r_vec == LAST_VEC) ? ST_DONE : ST_DRIVE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Vector, settle counter and mismatch bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec          <= 5'd0;
      r_settle       <= 4'd0;
      r_mismatch_cnt <= 6'd0;
      r_first_fail   <= 5'd0;
    end else if (w_start) begin
      r_vec          <= 5'd0;
      r_settle       <= 4'd0;
      r_mismatch_cnt <= 6'd0;
      r_first_fail   <= 5'd0;
    end else if (w_abort) begin
      r_vec    <= 5'd0;
      r_settle <= 4'd0;
    end else if (r_state == ST_DRIVE) begin
      r_settle <= r_settle + 4'd1;
    end else if (w_sample) begin
      if (bus.f_in != bus.g_in) begin
        r_mismatch_cnt <= r_mismatch_cnt + 6'd1;
        if (r_mismatch_cnt == 6'd0) begin
          r_first_fail <= r_vec;
        end
      end
      if (r_vec != LAST_VEC) begin
        r_vec    <= r_vec + 5'd1;
        r_settle <= 4'd0;
      end
    end
  end

  // Status flags; done/pass settle one edge after entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_busy <= is_busy(w_next_state);
      r_done <= (r_state == ST_DONE) && (w_next_state == ST_DONE);
      r_pass <= (r_state == ST_DONE) && (w_next_state == ST_DONE) &&
                (r_mismatch_cnt == 6'd0);
    end
  end

`ifdef LOGIC_SWEEP_MINTERM_LOG_EN
  logic [NVEC-1:0] r_minterms;

  // Truth-table capture of f_in, one bit per sampled vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_minterms <= 32'h0;
    end else if (w_start) begin
      r_minterms <= 32'h0;
    end else if (w_sample) begin
      r_minterms[r_vec] <= bus.f_in;
    end
  end

  assign bus.minterms = r_minterms;
`else
  assign bus.minterms = 32'h0;
`endif

  assign bus.abcde        = r_vec;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.pass         = r_pass;
  assign bus.mismatch_cnt = r_mismatch_cnt;
  assign bus.first_fail   = r_first_fail;

endmodule

// File: doc/logic_sweep_ctrl.md
Name: logic_sweep_ctrl

Overview:
- Sequencer that exhaustively drives all 32 A..E input combinations into a 5-input combinational function unit (homework-style boolean network) and compares its output against a second, minimized implementation.
- Reports pass/fail, mismatch count and the first failing vector.
- Sits in the lab bench/top level wrapping the function-under-test and its simplified equivalent, so equivalence of the two forms is proven in hardware.

Parameters:
- SETTLE, 1, cycles each vector is held before sampling (1..15)
- NVEC, 32, number of vectors swept (fixed 2^5; not to be overridden)

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse; begins a sweep when in IDLE or DONE
- abort  input  1  pulse; terminates a running sweep
- f_in  input  1  output of function-under-test
- g_in  input  1  output of minimized/reference function
- abcde  output  5  drive to both function units; [4]=A ... [0]=E
- busy  output  1  high while in DRIVE or SAMPLE
- done  output  1  high in DONE state, held until next start
- pass  output  1  valid with done; 1 when mismatch_cnt==0
- mismatch_cnt  output  6  number of vectors with f_in!=g_in (0..32)
- first_fail  output  5  first mismatching vector; 0 when mismatch_cnt==0
- minterms  output  32  truth table of f_in; see Optional Feature

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, all outputs 0: abcde, busy, done, pass, mismatch_cnt, first_fail, minterms.
  - Settle counter and vector counter are 0.
- States: IDLE, DRIVE, SAMPLE, DONE (2-bit encoding, constants in package).
- IDLE/DONE + start:
  - Next state DRIVE.
  - vec=0, mismatch_cnt=0, first_fail=0, done=0, pass=0, settle_cnt=0.
- DRIVE:
  - abcde=vec.
  - settle_cnt increments each cycle; at settle_cnt==SETTLE-1, go to SAMPLE.
- SAMPLE (1 cycle):
  - If f_in!=g_in: mismatch_cnt+=1; if mismatch_cnt was 0, first_fail=vec.
  - If vec==31: go to DONE. Otherwise vec+=1, settle_cnt=0, go to DRIVE.
  - vec is 5 bits; no wrap occurs because the 31 check precedes the increment.
- Latency:
  - Each vector takes SETTLE+1 cycles.
  - done rises at clock edge 1+32*(SETTLE+1) after the edge that samples start (65 with SETTLE=1).
- DONE:
  - done=1; pass=(mismatch_cnt==0).
  - abcde holds 5'd31.
  - Results hold until start or reset.
- start while busy: ignored, no restart.
- abort while busy: go to IDLE next edge. done=0, pass=0; mismatch_cnt and first_fail keep partial values; abcde=0.
- abort in IDLE/DONE: no effect.
- start and abort in the same cycle:
  - while busy, abort wins;
  - in IDLE/DONE, start wins.
- Reset mid-sweep: immediate return to reset values, independent of clk.
- mismatch_cnt saturation is unnecessary, since the maximum value is 32 and fits in 6 bits.

Optional Feature:
- Macro: LOGIC_SWEEP_MINTERM_LOG_EN.
- Defined:
  - In each SAMPLE, minterms[vec] is set to f_in.
  - minterms is cleared on start and holds the full truth table in DONE.
  - On abort, unsampled bits stay 0.
- Undefined: minterms tied to 32'h0, with no storage flops.

Decomposition:
- Package/header logic_sweep_defs:
  - state constants ST_IDLE=0, ST_DRIVE=1, ST_SAMPLE=2, ST_DONE=3;
  - NVEC=32;
  - LAST_VEC=5'd31.
- Natural sub-module: logic_sweep_top. It instantiates logic_sweep_ctrl plus the function-under-test and its minimized form, wiring abcde to both and their outputs to f_in/g_in.
- The controller itself stays a single module.

Test Plan:
1. Equivalent units: f = (A'BCD'+BCE')'+(C'D'+ABD), g = AD+AE+B'+C'+DE, SETTLE=1, start pulse. Required: done at edge 65, pass=1, mismatch_cnt=0, first_fail=0.
2. g_in forced to ~f_in. Required: mismatch_cnt=32, first_fail=5'd0, pass=0.
3. g_in differs from f_in only at abcde=5'b10110. Required: mismatch_cnt=1, first_fail=5'd22, pass=0.
4. Pulse start at cycle 10 of a sweep, then pulse abort at cycle 20. Required: second start is ignored; state IDLE at edge 21; done=0; busy=0; abcde=0.
5. Drop rst_n mid-sweep (cycle 30, between edges). Required: all outputs 0 immediately; a new start then completes a normal 65-edge sweep.
6. With LOGIC_SWEEP_MINTERM_LOG_EN and f_in tied 1. Required: minterms=32'hFFFF_FFFF at done. Without the macro, minterms=0 throughout.
